// File: rtl/snn_pkg.sv
// Shared SNN types and helpers: LIF FSM states, lane widths, reset-mode encoding.
package snn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} lif_state_t;

  localparam int VMEM_W = 8;
  localparam int CONV_W = VMEM_W + 1;

  localparam int RESET_ZERO = 0;
  localparam int RESET_SUB  = 1;

  // Spike vectors up to 64 lanes; callers zero-extend.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 8'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/lif_writeback_if.sv
// Conv-beat input, vmem write port, spike-word output and tile control/status.
interface lif_wb_if #(
  parameter int NUM_PE = 8,
  parameter int ADDR_W = 8
);
  import snn_pkg::*;

  logic                       start;
  logic [ADDR_W-1:0]          num_beats;
  logic [ADDR_W-1:0]          base_addr;
  logic [VMEM_W-1:0]          vth;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_PE*CONV_W-1:0]   conv_result;
  logic                       vm_wr_en;
  logic [ADDR_W-1:0]          vm_wr_addr;
  logic [NUM_PE*VMEM_W-1:0]   vm_wr_data;
  logic                       spk_valid;
  logic                       spk_ready;
  logic [NUM_PE-1:0]          spk_data;
  logic [ADDR_W-1:0]          spk_addr;
  logic [15:0]                spike_total;
  logic                       busy;
  logic                       done;

  modport master (
    output start, num_beats, base_addr, vth, in_valid, conv_result, spk_ready,
    input  in_ready, vm_wr_en, vm_wr_addr, vm_wr_data, spk_valid, spk_data,
           spk_addr, spike_total, busy, done
  );

  modport slave (
    input  start, num_beats, base_addr, vth, in_valid, conv_result, spk_ready,
    output in_ready, vm_wr_en, vm_wr_addr, vm_wr_data, spk_valid, spk_data,
           spk_addr, spike_total, busy, done
  );
endinterface

// File: rtl/lif_lane.sv
// Per-lane LIF update: reset on fire, saturating leak otherwise.
module lif_lane
  import snn_pkg::*;
#(
  parameter logic [VMEM_W-1:0] LEAK       = 8'd1,
  parameter int                RESET_MODE = RESET_ZERO
) (
  input  logic [VMEM_W-1:0] v,
  input  logic              s,
  input  logic [VMEM_W-1:0] vth,
  output logic [VMEM_W-1:0] nv
);
  always_comb begin
    nv = '0;
    if (s) begin
      if (RESET_MODE == RESET_SUB) nv = (v > vth) ? v - vth : '0;
    end else begin
      nv = (v > LEAK) ? v - LEAK : '0;
    end
  end
endmodule

// File: rtl/lif_writeback.sv
// LIF writeback stage: updates conv beats, writes vmem, emits one spike word per beat.
module lif_writeback
  import snn_pkg::*;
#(
  parameter int                NUM_PE     = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [VMEM_W-1:0] LEAK       = 8'd1,
  parameter int                RESET_MODE = RESET_ZERO
) (
  input logic     clk,
  input logic     nrst,
  lif_wb_if.slave bus
);
  lif_state_t                     state;
  logic [ADDR_W-1:0]              addr, remaining;
  logic [NUM_PE-1:0][VMEM_W-1:0]  nv;
  logic [NUM_PE-1:0]              s;
  logic                           accept;
  logic [16:0]                    sum;

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
    assign s[gi] = bus.conv_result[CONV_W*gi];
    lif_lane #(.LEAK(LEAK), .RESET_MODE(RESET_MODE)) u_lane (
      .v  (bus.conv_result[CONV_W*gi+1 +: VMEM_W]),
      .s  (s[gi]),
      .vth(bus.vth),
      .nv (nv[gi])
    );
  end

  assign bus.in_ready = (state == RUN) && (!bus.spk_valid || bus.spk_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state != IDLE);
  assign sum          = {1'b0, bus.spike_total} + 17'(popcount(64'(s)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      addr            <= '0;
      remaining       <= '0;
      bus.vm_wr_en    <= 1'b0;
      bus.vm_wr_addr  <= '0;
      bus.vm_wr_data  <= '0;
      bus.spk_valid   <= 1'b0;
      bus.spk_data    <= '0;
      bus.spk_addr    <= '0;
      bus.spike_total <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.vm_wr_en <= 1'b0;
      // Drain first; an accept in the same cycle reloads the register below.
      if (bus.spk_valid && bus.spk_ready) bus.spk_valid <= 1'b0;

      if (accept) begin
        bus.vm_wr_en    <= 1'b1;
        bus.vm_wr_addr  <= addr;
        bus.vm_wr_data  <= nv;
        bus.spk_valid   <= 1'b1;
        bus.spk_data    <= s;
        bus.spk_addr    <= addr;
        bus.spike_total <= sum[16] ? 16'hFFFF : sum[15:0];
        addr            <= addr + 1'b1;
        remaining       <= remaining - 1'b1;
      end

      case (state)
        IDLE: if (bus.start) begin
          bus.spike_total <= '0;
          addr            <= bus.base_addr;
          remaining       <= bus.num_beats;
          if (bus.num_beats == '0) bus.done <= 1'b1;
          else                     state    <= RUN;
        end
        RUN:   if (accept && remaining == 1) state <= DRAIN;
        DRAIN: if (!bus.spk_valid || bus.spk_ready) begin
          state    <= IDLE;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_writeback.sv
// Directed bench: two instances (reset-to-zero and subtract-vth) driven in lockstep.
module tb_lif_writeback;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  int   ncmp = 0, nfail = 0, wr_cnt = 0, snap;
  logic [8*9-1:0] c;

  always #5 clk = ~clk;

  lif_wb_if #(.NUM_PE(8), .ADDR_W(8)) ifa ();
  lif_wb_if #(.NUM_PE(8), .ADDR_W(8)) ifb ();

  assign ifb.start       = ifa.start;
  assign ifb.num_beats   = ifa.num_beats;
  assign ifb.base_addr   = ifa.base_addr;
  assign ifb.vth         = ifa.vth;
  assign ifb.in_valid    = ifa.in_valid;
  assign ifb.conv_result = ifa.conv_result;
  assign ifb.spk_ready   = ifa.spk_ready;

  lif_writeback #(.NUM_PE(8), .ADDR_W(8), .LEAK(8'd1), .RESET_MODE(RESET_ZERO))
    dut0 (.clk(clk), .nrst(nrst), .bus(ifa.slave));
  lif_writeback #(.NUM_PE(8), .ADDR_W(8), .LEAK(8'd1), .RESET_MODE(RESET_SUB))
    dut1 (.clk(clk), .nrst(nrst), .bus(ifb.slave));

  always @(posedge clk) if (ifa.vm_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_tile(input logic [7:0] nb, input logic [7:0] base);
    ifa.start = 1'b1; ifa.num_beats = nb; ifa.base_addr = base;
    tick();
    ifa.start = 1'b0;
  endtask

  function automatic logic [8*9-1:0] lane(input logic [8*9-1:0] cv, input int i,
                                          input logic [7:0] v, input logic sp);
    logic [8*9-1:0] r;
    r = cv;
    r[9*i +: 9] = {v, sp};
    return r;
  endfunction

  initial begin
    nrst = 1'b0;
    ifa.start = 1'b0; ifa.num_beats = '0; ifa.base_addr = '0; ifa.vth = 8'd40;
    ifa.in_valid = 1'b0; ifa.conv_result = '0; ifa.spk_ready = 1'b1;
    tick(); tick();
    chk("rst_wr_en", 64'(ifa.vm_wr_en), 0);
    chk("rst_spk_valid", 64'(ifa.spk_valid), 0);
    chk("rst_busy_done", 64'({ifa.busy, ifa.done, ifa.in_ready}), 0);
    chk("rst_total", 64'(ifa.spike_total), 0);
    nrst = 1'b1;
    tick();

    // 1: single beat, basic LIF
    start_tile(8'd1, 8'h10);
    chk("t1_busy", 64'({ifa.busy, ifa.in_ready}), 64'b11);
    c = '0; c = lane(c, 0, 8'd50, 1'b1); c = lane(c, 1, 8'd20, 1'b0);
    ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("t1_wr_en", 64'(ifa.vm_wr_en), 1);
    chk("t1_addr", 64'(ifa.vm_wr_addr), 64'h10);
    chk("t1_data", 64'(ifa.vm_wr_data), 64'h1300);
    chk("t1_spk", 64'({ifa.spk_valid, ifa.spk_data, ifa.spk_addr}), {1'b1, 8'h01, 8'h10});
    chk("t1_sub_data", 64'(ifb.vm_wr_data), 64'h130A);
    chk("t1_done_early", 64'(ifa.done), 0);
    tick();
    chk("t1_done", 64'({ifa.done, ifa.busy, ifa.vm_wr_en, ifa.spk_valid}), 64'b1000);
    chk("t1_total", 64'(ifa.spike_total), 1);
    tick();
    chk("t1_done_pulse", 64'(ifa.done), 0);
    chk("t1_total_hold", 64'(ifa.spike_total), 1);

    // 2: leak floors at zero
    start_tile(8'd1, 8'h20);
    c = '0; c = lane(c, 0, 8'd0, 1'b0); c = lane(c, 1, 8'd1, 1'b0); c = lane(c, 2, 8'd5, 1'b0);
    ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("t2_data", 64'(ifa.vm_wr_data), 64'h0004_0000);
    chk("t2_spk", 64'(ifa.spk_data), 0);
    chk("t2_total", 64'(ifa.spike_total), 0);
    tick(); tick();

    // 3: subtract-vth mode, back-to-back beats without bubble
    start_tile(8'd2, 8'h30);
    c = '0; c = lane(c, 0, 8'd50, 1'b1); c = lane(c, 1, 8'd30, 1'b1);
    ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    chk("t3_b1_sub", 64'(ifb.vm_wr_data), 64'h0A);
    chk("t3_b1_zero", 64'(ifa.vm_wr_data), 0);
    chk("t3_ready", 64'(ifa.in_ready), 1);
    c = '0; c = lane(c, 0, 8'd200, 1'b1); c = lane(c, 3, 8'd7, 1'b0);
    ifa.conv_result = c;
    tick();
    ifa.in_valid = 1'b0;
    chk("t3_b2_wr", 64'({ifa.vm_wr_en, ifa.vm_wr_addr, ifa.spk_valid}), {1'b1, 8'h31, 1'b1});
    chk("t3_b2_sub", 64'(ifb.vm_wr_data), 64'h0600_00A0);
    chk("t3_b2_zero", 64'(ifa.vm_wr_data), 64'h0600_0000);
    chk("t3_spk", 64'(ifa.spk_data), 64'h01);
    chk("t3_total", 64'(ifa.spike_total), 3);
    tick();
    chk("t3_done", 64'(ifa.done), 1);
    tick();

    // 4: backpressure, start ignored while busy
    snap = wr_cnt;
    ifa.spk_ready = 1'b0;
    start_tile(8'd3, 8'h40);
    c = '0; c = lane(c, 0, 8'd9, 1'b1);
    ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    chk("t4_b1", 64'({ifa.vm_wr_en, ifa.vm_wr_addr, ifa.in_ready}), {1'b1, 8'h40, 1'b0});
    ifa.start = 1'b1; ifa.base_addr = 8'h99; ifa.num_beats = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ifa.start = 1'b0;
      chk("t4_stall", 64'({ifa.vm_wr_en, ifa.in_ready, ifa.spk_valid, ifa.spk_data, ifa.spk_addr}),
          {1'b0, 1'b0, 1'b1, 8'h01, 8'h40});
    end
    ifa.spk_ready = 1'b1;
    tick();
    chk("t4_b2", 64'({ifa.vm_wr_en, ifa.vm_wr_addr}), {1'b1, 8'h41});
    tick();
    ifa.in_valid = 1'b0;
    chk("t4_b3", 64'({ifa.vm_wr_en, ifa.vm_wr_addr}), {1'b1, 8'h42});
    tick();
    chk("t4_done", 64'({ifa.done, ifa.busy}), 64'b10);
    tick();
    chk("t4_writes", 64'(wr_cnt - snap), 3);
    chk("t4_total", 64'(ifa.spike_total), 3);

    // 5: address wrap, then empty tile
    start_tile(8'd2, 8'hFF);
    c = '0; ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    chk("t5_addr_ff", 64'(ifa.vm_wr_addr), 64'hFF);
    tick();
    ifa.in_valid = 1'b0;
    chk("t5_addr_00", 64'({ifa.vm_wr_en, ifa.vm_wr_addr}), {1'b1, 8'h00});
    tick(); tick();
    snap = wr_cnt;
    start_tile(8'd0, 8'h55);
    chk("t5_zero_done", 64'({ifa.done, ifa.busy, ifa.vm_wr_en}), 64'b100);
    tick();
    chk("t5_zero_pulse", 64'(ifa.done), 0);
    tick();
    chk("t5_zero_writes", 64'(wr_cnt - snap), 0);

    // 6: reset mid-tile, then a clean restart
    start_tile(8'd4, 8'h50);
    c = '0; c = lane(c, 2, 8'd3, 1'b1); ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("t6_total_pre", 64'(ifa.spike_total), 1);
    nrst = 1'b0;
    #1;
    chk("t6_rst", 64'({ifa.vm_wr_en, ifa.spk_valid, ifa.busy, ifa.done, ifa.in_ready}), 0);
    chk("t6_rst_total", 64'(ifa.spike_total), 0);
    tick();
    nrst = 1'b1;
    tick();
    start_tile(8'd1, 8'h60);
    c = '0; c = lane(c, 4, 8'd1, 1'b1); c = lane(c, 7, 8'd1, 1'b1);
    ifa.conv_result = c; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("t6_restart", 64'({ifa.vm_wr_addr, ifa.spk_data}), {8'h60, 8'h90});
    chk("t6_total", 64'(ifa.spike_total), 2);
    tick();
    chk("t6_done", 64'(ifa.done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
